// File: rtl/pwm_pkg.sv
// Shared PWM definitions: dead-time counter width and FSM state encoding.
// Imported by the dead-time stage and the PWM peripheral.
package pwm_pkg;

    localparam int PWM_DT_WIDTH = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOW_ON,
        ST_DT_RISE,
        ST_HIGH_ON,
        ST_DT_FALL,
        ST_FAULT
    } pwm_dt_state_e;

endpackage

// File: rtl/pwm_deadtime_if.sv
// Bundle between a PWM channel and its dead-time stage.
// master: peripheral/controller side, slave: dead-time stage side.
interface pwm_deadtime_if
    import pwm_pkg::*;
#(
    parameter int DT_WIDTH = PWM_DT_WIDTH
);
    logic                pwm_i;
    logic                oe_i;
    logic                en_i;
    logic [DT_WIDTH-1:0] dt_rise_i;
    logic [DT_WIDTH-1:0] dt_fall_i;
    logic                fault_i;
    logic                fault_clr_i;
    logic                pwm_h_o;
    logic                pwm_l_o;
    logic                oe_o;
    logic                fault_o;

    modport master (
        output pwm_i, oe_i, en_i, dt_rise_i, dt_fall_i,
        output fault_i, fault_clr_i,
        input  pwm_h_o, pwm_l_o, oe_o, fault_o
    );

    modport slave (
        input  pwm_i, oe_i, en_i, dt_rise_i, dt_fall_i,
        input  fault_i, fault_clr_i,
        output pwm_h_o, pwm_l_o, oe_o, fault_o
    );
endinterface

// File: rtl/pwm_deadtime.sv
// Dead-time insertion: one PWM level in, complementary gate pair out.
// Ports: clk_i/rst_ni, pwm/oe/en/dt_rise/dt_fall/fault/fault_clr in; h/l/oe/fault out.
module pwm_deadtime
    import pwm_pkg::*;
#(
    parameter int DT_WIDTH = PWM_DT_WIDTH
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                pwm_i,
    input  logic                oe_i,
    input  logic                en_i,
    input  logic [DT_WIDTH-1:0] dt_rise_i,
    input  logic [DT_WIDTH-1:0] dt_fall_i,
    input  logic                fault_i,
    input  logic                fault_clr_i,
    output logic                pwm_h_o,
    output logic                pwm_l_o,
    output logic                oe_o,
    output logic                fault_o
);

    localparam logic [DT_WIDTH-1:0] CNT_ONE = DT_WIDTH'(1);

    logic                r_pwm_q;
    pwm_dt_state_e       r_state;
    logic [DT_WIDTH-1:0] r_cnt;
    logic                r_h;
    logic                r_l;
    logic                r_oe;
    logic                r_fault;
    logic                w_run;

    assign w_run = en_i & oe_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pwm_q <= 1'b0;
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_h     <= 1'b0;
            r_l     <= 1'b0;
            r_oe    <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            r_pwm_q <= pwm_i;
            if (fault_i) begin
                r_state <= ST_FAULT;
                r_cnt   <= '0;
                r_h     <= 1'b0;
                r_l     <= 1'b0;
                r_oe    <= 1'b0;
                r_fault <= 1'b1;
            end else if (r_state == ST_FAULT) begin
                if (fault_clr_i) begin
                    r_state <= ST_IDLE;
                    r_fault <= 1'b0;
                end
            end else if (!w_run) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
                r_h     <= 1'b0;
                r_l     <= 1'b0;
                r_oe    <= 1'b0;
            end else begin
                r_oe <= 1'b1;
                unique case (r_state)
                    // Both gates already off, so no dead time on entry.
                    ST_IDLE: begin
                        r_state <= r_pwm_q ? ST_HIGH_ON : ST_LOW_ON;
                        r_h     <= r_pwm_q;
                        r_l     <= ~r_pwm_q;
                    end
                    ST_LOW_ON: begin
                        if (r_pwm_q) begin
                            r_l <= 1'b0;
                            if (dt_rise_i == '0) begin
                                r_state <= ST_HIGH_ON;
                                r_h     <= 1'b1;
                            end else begin
                                r_state <= ST_DT_RISE;
                                r_cnt   <= dt_rise_i;
                            end
                        end
                    end
                    ST_DT_RISE: begin
                        // A pulse shorter than the dead time is swallowed.
                        if (!r_pwm_q) begin
                            r_state <= ST_LOW_ON;
                            r_cnt   <= '0;
                            r_l     <= 1'b1;
                        end else if (r_cnt == CNT_ONE) begin
                            r_state <= ST_HIGH_ON;
                            r_cnt   <= '0;
                            r_h     <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt - CNT_ONE;
                        end
                    end
                    ST_HIGH_ON: begin
                        if (!r_pwm_q) begin
                            r_h <= 1'b0;
                            if (dt_fall_i == '0) begin
                                r_state <= ST_LOW_ON;
                                r_l     <= 1'b1;
                            end else begin
                                r_state <= ST_DT_FALL;
                                r_cnt   <= dt_fall_i;
                            end
                        end
                    end
                    ST_DT_FALL: begin
                        if (r_pwm_q) begin
                            r_state <= ST_HIGH_ON;
                            r_cnt   <= '0;
                            r_h     <= 1'b1;
                        end else if (r_cnt == CNT_ONE) begin
                            r_state <= ST_LOW_ON;
                            r_cnt   <= '0;
                            r_l     <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt - CNT_ONE;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_h     <= 1'b0;
                        r_l     <= 1'b0;
                        r_oe    <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Fault kills the gates combinationally, ahead of the state update.
    assign pwm_h_o = r_h & ~fault_i;
    assign pwm_l_o = r_l & ~fault_i;
    assign oe_o    = r_oe;
    assign fault_o = r_fault;

endmodule

// File: tb/tb_pwm_deadtime.sv
// Self-checking bench for pwm_deadtime: directed timing checks plus
// randomized stimulus against a run-length behavioural model.
module tb_pwm_deadtime;

    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    pwm_deadtime_if #(.DT_WIDTH(DW)) bus ();

    pwm_deadtime #(.DT_WIDTH(DW)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .pwm_i      (bus.pwm_i),
        .oe_i       (bus.oe_i),
        .en_i       (bus.en_i),
        .dt_rise_i  (bus.dt_rise_i),
        .dt_fall_i  (bus.dt_fall_i),
        .fault_i    (bus.fault_i),
        .fault_clr_i(bus.fault_clr_i),
        .pwm_h_o    (bus.pwm_h_o),
        .pwm_l_o    (bus.pwm_l_o),
        .oe_o       (bus.oe_o),
        .fault_o    (bus.fault_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Model: gates follow a committed level; a mismatching pwm_q run turns
    // both gates off and commits the new level once it lasts D+1 samples.
    logic m_act, m_flt, m_lvl, m_pq;
    int   m_run, m_dt;

    always @(posedge clk or negedge rst_n) begin
        logic a, f, lv;
        int   r, d;
        if (!rst_n) begin
            m_act <= 1'b0; m_flt <= 1'b0; m_lvl <= 1'b0;
            m_pq  <= 1'b0; m_run <= 0;    m_dt  <= 0;
        end else begin
            a = m_act; f = m_flt; lv = m_lvl; r = m_run; d = m_dt;
            if (bus.fault_i) begin
                f = 1'b1; a = 1'b0; r = 0;
            end else if (f) begin
                if (bus.fault_clr_i) f = 1'b0;
            end else if (!(bus.en_i && bus.oe_i)) begin
                a = 1'b0; r = 0;
            end else if (!a) begin
                a = 1'b1; lv = m_pq; r = 0;
            end else if (m_pq != lv) begin
                r = r + 1;
                if (r == 1) d = lv ? int'(bus.dt_fall_i) : int'(bus.dt_rise_i);
                if (r == d + 1) begin
                    lv = m_pq; r = 0;
                end
            end else begin
                r = 0;
            end
            m_act <= a; m_flt <= f; m_lvl <= lv; m_run <= r; m_dt <= d;
            m_pq  <= bus.pwm_i;
        end
    end

    always @(posedge clk) begin
        logic eh, el;
        #2;
        eh = m_act && (m_run == 0) && m_lvl && !bus.fault_i;
        el = m_act && (m_run == 0) && !m_lvl && !bus.fault_i;
        check("model_h", bus.pwm_h_o, eh);
        check("model_l", bus.pwm_l_o, el);
        check("model_oe", bus.oe_o, m_act);
        check("model_fault", bus.fault_o, m_flt);
        check("no_overlap", bus.pwm_h_o & bus.pwm_l_o, 1'b0);
    end

    task automatic eg(input string name, input logic h, input logic l);
        @(negedge clk);
        check({name, "_h"}, bus.pwm_h_o, h);
        check({name, "_l"}, bus.pwm_l_o, l);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        bus.pwm_i = 0; bus.oe_i = 0; bus.en_i = 0;
        bus.dt_rise_i = 3; bus.dt_fall_i = 5;
        bus.fault_i = 0; bus.fault_clr_i = 0;
        #12;
        check("rst_h", bus.pwm_h_o, 1'b0);
        check("rst_l", bus.pwm_l_o, 1'b0);
        check("rst_oe", bus.oe_o, 1'b0);
        check("rst_fault", bus.fault_o, 1'b0);
        cyc(2);
        rst_n = 1;
        cyc(2);

        // Enable: first gate one cycle later.
        bus.en_i = 1; bus.oe_i = 1;
        eg("en", 1'b0, 1'b1);
        check("en_oe", bus.oe_o, 1'b1);
        cyc(3);

        // Rise with D=3, fall with D=5.
        bus.pwm_i = 1;
        eg("r_k", 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) eg("r_dead", 1'b0, 1'b0);
        eg("r_on", 1'b1, 1'b0);
        cyc(15);
        bus.pwm_i = 0;
        eg("f_k", 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) eg("f_dead", 1'b0, 1'b0);
        eg("f_on", 1'b0, 1'b1);
        cyc(14);

        // Zero dead time: swap on one edge.
        bus.dt_rise_i = 0; bus.dt_fall_i = 0;
        bus.pwm_i = 1;
        eg("z0_k", 1'b0, 1'b1);
        eg("z0_sw", 1'b1, 1'b0);
        cyc(3);
        bus.pwm_i = 0;
        eg("z1_k", 1'b1, 1'b0);
        eg("z1_sw", 1'b0, 1'b1);
        cyc(3);

        // Short pulse swallowed by dt_rise=6.
        bus.dt_rise_i = 6; bus.dt_fall_i = 5;
        bus.pwm_i = 1;
        eg("sp_k", 1'b0, 1'b1);
        eg("sp_dead", 1'b0, 1'b0);
        bus.pwm_i = 0;
        eg("sp_dead2", 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) eg("sp_back", 1'b0, 1'b1);

        // Fault while HIGH_ON.
        bus.dt_rise_i = 2;
        bus.pwm_i = 1;
        cyc(6);
        check("pre_flt_h", bus.pwm_h_o, 1'b1);
        bus.fault_i = 1;
        #1;
        check("flt_comb_h", bus.pwm_h_o, 1'b0);
        check("flt_comb_l", bus.pwm_l_o, 1'b0);
        check("flt_o_early", bus.fault_o, 1'b0);
        @(negedge clk);
        check("flt_latch", bus.fault_o, 1'b1);
        bus.fault_i = 0;
        @(negedge clk);
        check("flt_sticky", bus.fault_o, 1'b1);
        check("flt_sticky_h", bus.pwm_h_o, 1'b0);
        bus.fault_clr_i = 1; bus.fault_i = 1;
        @(negedge clk);
        check("flt_clr_ign", bus.fault_o, 1'b1);
        bus.fault_i = 0;
        @(negedge clk);
        check("flt_clr", bus.fault_o, 1'b0);
        check("flt_idle_oe", bus.oe_o, 1'b0);
        check("flt_idle_h", bus.pwm_h_o, 1'b0);
        bus.fault_clr_i = 0;
        @(negedge clk);
        check("flt_resume_h", bus.pwm_h_o, 1'b1);
        check("flt_resume_oe", bus.oe_o, 1'b1);
        cyc(2);

        // oe_i dropped mid DT_FALL.
        bus.pwm_i = 0;
        eg("oe_k", 1'b1, 1'b0);
        eg("oe_dead", 1'b0, 1'b0);
        bus.oe_i = 0;
        eg("oe_drop", 1'b0, 1'b0);
        check("oe_drop_oe", bus.oe_o, 1'b0);
        bus.oe_i = 1;
        eg("oe_back", 1'b0, 1'b1);
        cyc(2);

        // dt change mid-count, then async reset while HIGH_ON.
        bus.dt_rise_i = 4;
        bus.pwm_i = 1;
        eg("dc_k", 1'b0, 1'b1);
        eg("dc_d0", 1'b0, 1'b0);
        bus.dt_rise_i = 1;
        for (int i = 0; i < 3; i++) eg("dc_d", 1'b0, 1'b0);
        eg("dc_on", 1'b1, 1'b0);
        #2;
        rst_n = 0;
        #1;
        check("ar_h", bus.pwm_h_o, 1'b0);
        check("ar_l", bus.pwm_l_o, 1'b0);
        check("ar_oe", bus.oe_o, 1'b0);
        check("ar_fault", bus.fault_o, 1'b0);
        @(negedge clk);
        rst_n = 1;
        eg("ar_lo", 1'b0, 1'b1);
        eg("ar_dead", 1'b0, 1'b0);
        eg("ar_new_dt", 1'b1, 1'b0);

        // Randomized phase against the model.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 5) == 0) bus.pwm_i = ~bus.pwm_i;
            if ($urandom_range(0, 7) == 0) bus.dt_rise_i = DW'($urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0) bus.dt_fall_i = DW'($urandom_range(0, 7));
            bus.en_i = ($urandom_range(0, 99) != 0);
            bus.oe_i = ($urandom_range(0, 99) != 0);
            bus.fault_i = ($urandom_range(0, 199) == 0);
            bus.fault_clr_i = ($urandom_range(0, 9) == 0);
        end
        cyc(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
